commit_trace_tx: RTL and testbench
==================================

# commit_trace_tx

Synthesizable commit-trace transmitter that sits beside the retire stage of the processor. It captures up to two retired, non-flushed instructions per cycle into a trace FIFO and serializes each record onto a 16-bit valid/ready stream for an off-chip trace reader. It also runs a PC-hang watchdog that flags end-of-program or deadlock.

## Interface
Parameters:
- DEPTH, 16: trace FIFO entries; power of two, at least 4.
- HANG_CYCLES, 2000: consecutive unchanged-PC cycles before hang_o asserts.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- c0_valid_commit, c0_flushed, c0_valid_write, inputs, 1 each: retire slot 0 qualifiers.
- c0_pc, input, 32: retire slot 0 PC.
- c0_pdst, input, 6: retire slot 0 destination register.
- c0_data, input, 32: retire slot 0 writeback data.
- c1_valid_commit, c1_flushed, c1_valid_write, c1_pc, c1_pdst, c1_data: retire slot 1, same widths as slot 0.
- current_pc_i, input, 32: fetch PC used by the watchdog.
- out_valid, output, 1: beat valid.
- out_ready, input, 1: reader accepts beat.
- out_data, output, 16: beat payload.
- out_last, output, 1: final beat of a record.
- hang_o, output, 1: sticky watchdog flag.
- drop_count_o, output, 16: saturating count of dropped records.

## Operation
- Slot 0 is accepted when c0_valid_commit & !c0_flushed.
- Slot 1 is accepted only when slot 0 is accepted and c1_valid_commit & !c1_flushed. Slot 1 is ignored otherwise.
- Record is 80 bits: {seq[7:0], pdst[5:0], valid_write, gap, pc[31:0], data[31:0]}.
- seq is an 8-bit counter that wraps 255 to 0. It advances once per accepted record, including dropped records, so the reader can detect gaps.
- gap is set on the first enqueued record after one or more drops, then cleared.
- Free slots equal DEPTH - count, sampled before any pop in the same cycle. A pop does not free a slot for that cycle's pushes.
- When one slot is free and two records arrive, slot 0 is enqueued and slot 1 is dropped.
- Each drop increments drop_count_o by 1, saturating at 0xFFFF. A dual drop increments it by 2, saturating.
- Serializer FSM has states IDLE and SEND.
  - Beat index runs 0 to 4.
  - IDLE moves to SEND when the FIFO is non-empty, loading the head record.
  - Beats are sent in this order:
    - beat 0: {seq, pdst, valid_write, gap}
    - beat 1: pc[31:16]
    - beat 2: pc[15:0]
    - beat 3: data[31:16]
    - beat 4: data[15:0], with out_last = 1
  - The index advances only on out_valid & out_ready.
  - When beat 4 is accepted, the FIFO pops. If more records remain, the FSM stays in SEND with index 0 and loads the next head. Otherwise it returns to IDLE.
- Watchdog behaviour:
  - An internal register samples current_pc_i every cycle.
  - The counter increments when current_pc_i equals the previous sample and clears to 0 otherwise.
  - hang_o sets when the counter reaches HANG_CYCLES and stays set until reset.
  - The counter saturates at HANG_CYCLES.

## Timing
- Reset values:
  - out_valid = 0, out_last = 0, out_data = 0.
  - hang_o = 0, drop_count_o = 0.
  - seq = 0, gap = 0, FIFO empty, FSM in IDLE, watchdog counter 0.
- All outputs are registered. out_valid does not depend combinationally on out_ready.
- A record pushed in cycle N presents beat 0 no earlier than cycle N+1.
- While out_valid = 1 and out_ready = 0, out_data and out_last hold stable.
- With out_ready held high, a record takes exactly 5 cycles. Back-to-back records are sent with no idle beat.
- Push and pop in the same cycle are legal. count updates by pushes minus pop.
- Reset mid-record abandons the record. No partial beat is presented after reset release.
- hang_o asserts on the cycle the counter first equals HANG_CYCLES. This is HANG_CYCLES cycles after the first repeated-PC cycle.

## Structure
- Define the trace_record typedef (80-bit packed) and the TRACE_BEATS = 5 constant in structs.sv.
- Put the FIFO in one sub-module, commit_trace_fifo: two write ports, one read port, DEPTH-parameterized, with wrap-around pointers and a count.
- The FSM, the seq/gap/drop logic and the watchdog live in commit_trace_tx.

## Test plan
- Single commit, pc=0x80000010, pdst=5, valid_write=1, data=0xDEADBEEF, out_ready=1 -> beats 0x0016, 0x8000, 0x0010, 0xDEAD, 0xBEEF. out_last is high only on the fifth beat. seq = 0.
- Dual commit in one cycle, slot 1 flushed -> exactly one record. Dual commit with slot 0 flushed and slot 1 valid -> no record.
- out_ready=0 with 18 dual commits, DEPTH=16 -> 16 records enqueued and drop_count_o = 20. On drain, seq values run 0 to 15. The next enqueued record carries seq=36 and gap=1.
- Random out_ready toggling across 40 records -> out_data is stable during stalls and all 40 records arrive in order. seq wraps correctly when preloaded past 250 by prior traffic.
- current_pc_i held constant, HANG_CYCLES=2000 -> hang_o rises exactly 2000 cycles after the first repeat. A PC change at cycle 1999 clears the count and hang_o stays 0.
- rst_n asserted during beat 2 -> all outputs go to their reset values immediately. After release, the first record starts at beat 0 with seq=0.

Source files
------------

// File: rtl/commit_trace_tx_pkg.sv
// Shared types for the commit-trace transmitter: the 80-bit trace record,
// serializer state encoding and small helpers used by the top and the FIFO.
package commit_trace_tx_pkg;

    localparam int TRACE_BEATS = 5;
    localparam int BEAT_W      = 16;

    typedef struct packed {
        logic [7:0]  seq;
        logic [5:0]  pdst;
        logic        valid_write;
        logic        gap;
        logic [31:0] pc;
        logic [31:0] data;
    } trace_record;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    function automatic logic [BEAT_W-1:0] beat_word(input trace_record rec,
                                                    input logic [2:0]  idx);
        logic [BEAT_W-1:0] w;
        case (idx)
            3'd0:    w = {rec.seq, rec.pdst, rec.valid_write, rec.gap};
            3'd1:    w = rec.pc[31:16];
            3'd2:    w = rec.pc[15:0];
            3'd3:    w = rec.data[31:16];
            default: w = rec.data[15:0];
        endcase
        return w;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [1:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Trace record FIFO: two write ports (slot 0 lands first), one read port with
// a peek at the entry behind the head so the serializer can chain records.
module commit_trace_fifo
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr0_en,
    input  trace_record wr0_data,
    input  logic        wr1_en,
    input  trace_record wr1_data,
    input  logic        rd_en,
    output trace_record head,
    output trace_record head_next,
    output logic [AW:0] count
);

    trace_record   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr1_addr;
    logic [1:0]    n_push;

    assign n_push   = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign wr1_addr = wr0_en ? wr_ptr + AW'(1) : wr_ptr;

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]   <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + (AW+1)'(n_push) - (AW+1)'(rd_en);
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: captures retired instructions into a FIFO,
// serializes records as five 16-bit beats, and runs a PC-hang watchdog.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | nothing presented; loads the FIFO head when non-empty
//   ST_SEND | presenting beat beat_idx of cur_rec; chains to next record
module commit_trace_tx
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HANG_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c0_valid_commit,
    input  logic        c0_flushed,
    input  logic        c0_valid_write,
    input  logic [31:0] c0_pc,
    input  logic [5:0]  c0_pdst,
    input  logic [31:0] c0_data,
    input  logic        c1_valid_commit,
    input  logic        c1_flushed,
    input  logic        c1_valid_write,
    input  logic [31:0] c1_pc,
    input  logic [5:0]  c1_pdst,
    input  logic [31:0] c1_data,
    input  logic [31:0] current_pc_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        hang_o,
    output logic [15:0] drop_count_o
);

    localparam int AW            = $clog2(DEPTH);
    localparam int HW            = $clog2(HANG_CYCLES + 1);
    localparam logic [2:0] LAST_BEAT = 3'(TRACE_BEATS - 1);
    localparam logic [HW-1:0] HANG_MAX = HW'(HANG_CYCLES);

    logic        acc0, acc1;
    logic        push0, push1;
    logic        drop0, drop1;
    logic [AW:0] count;
    logic [AW:0] free_slots;
    logic [1:0]  n_acc;
    logic [1:0]  n_drop;
    logic [7:0]  seq_q;
    logic        gap_pend;
    trace_record rec0, rec1;
    trace_record head, head_next;
    trace_record cur_rec;
    tx_state_e   state;
    logic [2:0]  beat_idx;
    logic [2:0]  nxt_idx;
    logic        pop;

    // Free slots are judged on the pre-pop count, so a pop never makes room
    // for pushes in the same cycle.
    assign acc0       = c0_valid_commit & ~c0_flushed;
    assign acc1       = acc0 & c1_valid_commit & ~c1_flushed;
    assign free_slots = (AW+1)'(DEPTH) - count;
    assign push0      = acc0 && (free_slots != '0);
    assign push1      = acc1 && (free_slots >= (AW+1)'(2));
    assign drop0      = acc0 & ~push0;
    assign drop1      = acc1 & ~push1;
    assign n_acc      = {1'b0, acc0} + {1'b0, acc1};
    assign n_drop     = {1'b0, drop0} + {1'b0, drop1};

    always_comb begin
        rec0             = '0;
        rec0.seq         = seq_q;
        rec0.pdst        = c0_pdst;
        rec0.valid_write = c0_valid_write;
        rec0.gap         = gap_pend;
        rec0.pc          = c0_pc;
        rec0.data        = c0_data;
        // Slot 1 only enqueues behind slot 0, which has already consumed the gap.
        rec1             = '0;
        rec1.seq         = seq_q + 8'd1;
        rec1.pdst        = c1_pdst;
        rec1.valid_write = c1_valid_write;
        rec1.gap         = 1'b0;
        rec1.pc          = c1_pc;
        rec1.data        = c1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q        <= '0;
            gap_pend     <= 1'b0;
            drop_count_o <= '0;
        end else begin
            seq_q        <= seq_q + {6'd0, n_acc};
            drop_count_o <= sat_add16(drop_count_o, n_drop);
            if (drop0 || drop1)
                gap_pend <= 1'b1;
            else if (push0)
                gap_pend <= 1'b0;
        end
    end

    commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr0_en    (push0),
        .wr0_data  (rec0),
        .wr1_en    (push1),
        .wr1_data  (rec1),
        .rd_en     (pop),
        .head      (head),
        .head_next (head_next),
        .count     (count)
    );

    assign nxt_idx = beat_idx + 3'd1;
    assign pop     = (state == ST_SEND) && out_valid && out_ready && (beat_idx == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat_idx  <= '0;
            cur_rec   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state     <= ST_SEND;
                        cur_rec   <= head;
                        beat_idx  <= '0;
                        out_valid <= 1'b1;
                        out_data  <= beat_word(head, 3'd0);
                        out_last  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (out_valid && out_ready) begin
                        if (beat_idx == LAST_BEAT) begin
                            // head_next is only valid if it was stored before this cycle
                            if (count > (AW+1)'(1)) begin
                                cur_rec  <= head_next;
                                beat_idx <= '0;
                                out_data <= beat_word(head_next, 3'd0);
                                out_last <= 1'b0;
                            end else begin
                                state     <= ST_IDLE;
                                beat_idx  <= '0;
                                out_valid <= 1'b0;
                                out_data  <= '0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            beat_idx <= nxt_idx;
                            out_data <= beat_word(cur_rec, nxt_idx);
                            out_last <= (nxt_idx == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    logic [31:0]   pc_prev;
    logic [HW-1:0] hang_cnt;
    logic [HW-1:0] hang_cnt_nxt;

    always_comb begin
        hang_cnt_nxt = '0;
        if (current_pc_i == pc_prev)
            hang_cnt_nxt = (hang_cnt == HANG_MAX) ? hang_cnt : hang_cnt + HW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_prev  <= '0;
            hang_cnt <= '0;
            hang_o   <= 1'b0;
        end else begin
            pc_prev  <= current_pc_i;
            hang_cnt <= hang_cnt_nxt;
            if (hang_cnt_nxt == HANG_MAX) hang_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: directed steps plus randomized
// traffic checked against a queue-based record model.
module tb_commit_trace_tx;

    localparam int DEPTH = 16;
    localparam int HANG  = 2000;

    logic        clk;
    logic        rst_n;
    logic        c0_valid_commit, c0_flushed, c0_valid_write;
    logic [31:0] c0_pc, c0_data;
    logic [5:0]  c0_pdst;
    logic        c1_valid_commit, c1_flushed, c1_valid_write;
    logic [31:0] c1_pc, c1_data;
    logic [5:0]  c1_pdst;
    logic [31:0] current_pc_i;
    logic        out_valid, out_ready, out_last, hang_o;
    logic [15:0] out_data, drop_count_o;

    commit_trace_tx #(.DEPTH(DEPTH), .HANG_CYCLES(HANG)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_valid_commit(c0_valid_commit), .c0_flushed(c0_flushed),
        .c0_valid_write(c0_valid_write), .c0_pc(c0_pc), .c0_pdst(c0_pdst), .c0_data(c0_data),
        .c1_valid_commit(c1_valid_commit), .c1_flushed(c1_flushed),
        .c1_valid_write(c1_valid_write), .c1_pc(c1_pc), .c1_pdst(c1_pdst), .c1_data(c1_data),
        .current_pc_i(current_pc_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .hang_o(hang_o), .drop_count_o(drop_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic [79:0] exp_q[$];
    logic [7:0]  m_seq;
    bit          m_gap;
    int          m_drops;
    int          beat_i;
    int          m_run;
    logic [31:0] m_prev_pc;
    bit          m_hang;
    int          rx_count = 0;
    bit          stall_prev;
    logic [15:0] stall_data;
    logic        stall_last;
    bit          pc_hold = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_slot(input logic [5:0] pdst, input logic vw,
                               input logic [31:0] pc, input logic [31:0] data);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back({m_seq, pdst, vw, m_gap, pc, data});
            m_gap = 0;
        end else begin
            m_gap = 1;
            if (m_drops < 65535) m_drops++;
        end
        m_seq = m_seq + 8'd1;
    endtask

    // One clock: check what is presented now, update the model with this
    // cycle's handshake and commits, then advance to just after the edge.
    task automatic tick();
        bit          pop;
        logic [79:0] r;
        pop = 0;
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, stall_data);
            chk("stall_last", out_last, stall_last);
        end
        if (out_valid) begin
            chk("valid_has_record", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                r = exp_q[0];
                chk("beat_data", out_data, r[79-16*beat_i -: 16]);
                chk("beat_last", out_last, beat_i == 4);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;
        if (out_valid && out_ready) begin
            beat_i++;
            if (beat_i == 5) begin
                beat_i = 0;
                pop = 1;
                rx_count++;
            end
        end
        if (c0_valid_commit && !c0_flushed) begin
            accept_slot(c0_pdst, c0_valid_write, c0_pc, c0_data);
            if (c1_valid_commit && !c1_flushed)
                accept_slot(c1_pdst, c1_valid_write, c1_pc, c1_data);
        end
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (current_pc_i == m_prev_pc) begin
            if (m_run < HANG) m_run++;
        end else begin
            m_run = 0;
        end
        m_prev_pc = current_pc_i;
        if (m_run == HANG) m_hang = 1;
        @(posedge clk);
        #1;
        chk("drop_count", drop_count_o, m_drops);
        chk("hang", hang_o, m_hang);
        if (!pc_hold) current_pc_i = $urandom;
    endtask

    task automatic clear_commits();
        c0_valid_commit = 0; c0_flushed = 0; c0_valid_write = 0;
        c0_pc = '0; c0_pdst = '0; c0_data = '0;
        c1_valid_commit = 0; c1_flushed = 0; c1_valid_write = 0;
        c1_pc = '0; c1_pdst = '0; c1_data = '0;
    endtask

    task automatic rand_commits(input int valid_pct, input int flush_pct);
        c0_valid_commit = 1'($urandom_range(0, 99) < valid_pct);
        c0_flushed      = 1'($urandom_range(0, 99) < flush_pct);
        c0_valid_write  = 1'($urandom_range(0, 1));
        c0_pc           = $urandom;
        c0_pdst         = 6'($urandom_range(0, 63));
        c0_data         = $urandom;
        c1_valid_commit = 1'($urandom_range(0, 99) < valid_pct);
        c1_flushed      = 1'($urandom_range(0, 99) < flush_pct);
        c1_valid_write  = 1'($urandom_range(0, 1));
        c1_pc           = $urandom;
        c1_pdst         = 6'($urandom_range(0, 63));
        c1_data         = $urandom;
    endtask

    task automatic do_reset();
        clear_commits();
        rst_n = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_hang", hang_o, 0);
        chk("rst_drop_count", drop_count_o, 0);
        exp_q.delete();
        m_seq = 0; m_gap = 0; m_drops = 0; beat_i = 0;
        m_run = 0; m_prev_pc = '0; m_hang = 0; stall_prev = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic drain(input bit rand_ready, input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || out_valid); i++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) tick();
        chk("wait_valid", out_valid, 1);
    endtask

    initial begin
        int rx0;
        rst_n = 1;
        out_ready = 1;
        current_pc_i = 32'h1000;
        clear_commits();
        #2;
        do_reset();

        // Single commit with the documented beat pattern
        out_ready = 1;
        c0_valid_commit = 1; c0_valid_write = 1; c0_pc = 32'h8000_0010;
        c0_pdst = 6'd5; c0_data = 32'hDEAD_BEEF;
        rx0 = rx_count;
        tick();
        clear_commits();
        wait_valid(4);
        chk("single_beat0", out_data, 16'h0016);
        drain(0, 50);
        chk("single_records", rx_count - rx0, 1);

        // Slot 1 flushed -> one record; slot 0 flushed -> none
        rx0 = rx_count;
        rand_commits(100, 0);
        c1_flushed = 1;
        tick();
        clear_commits();
        drain(0, 50);
        chk("slot1_flushed_records", rx_count - rx0, 1);
        rx0 = rx_count;
        rand_commits(100, 0);
        c0_flushed = 1;
        tick();
        clear_commits();
        repeat (8) tick();
        chk("slot0_flushed_records", rx_count - rx0, 0);
        chk("slot0_flushed_idle", out_valid, 0);

        // Overflow: 18 dual commits against a stalled reader
        do_reset();
        out_ready = 0;
        repeat (18) begin
            rand_commits(100, 0);
            tick();
        end
        clear_commits();
        tick();
        chk("overflow_drops", drop_count_o, 20);
        chk("overflow_head_seq", out_data[15:8], 0);
        drain(0, 200);
        c0_valid_commit = 1; c0_pc = $urandom; c0_data = $urandom; c0_pdst = 6'd9;
        tick();
        clear_commits();
        wait_valid(4);
        chk("after_drop_seq", out_data[15:8], 36);
        chk("after_drop_gap", out_data[0], 1);
        drain(0, 50);

        // Preload seq near the wrap point, then random traffic with stalls
        for (int i = 0; i < 3000 && m_seq < 8'd251; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            rand_commits(90, 10);
            tick();
        end
        chk("preload_reached", m_seq >= 8'd251, 1);
        clear_commits();
        drain(1, 400);
        rx0 = rx_count;
        for (int i = 0; i < 3000 && (rx_count - rx0) < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            rand_commits(30, 20);
            tick();
        end
        clear_commits();
        drain(1, 800);
        chk("random_records", (rx_count - rx0) >= 40, 1);

        // Reset while beat 2 is on the bus
        out_ready = 1;
        c0_valid_commit = 1; c0_pc = $urandom; c0_data = $urandom; c0_pdst = 6'd3;
        tick();
        clear_commits();
        for (int i = 0; i < 10 && !(out_valid && beat_i == 2); i++) tick();
        chk("reached_beat2", beat_i, 2);
        do_reset();
        c0_valid_commit = 1; c0_valid_write = 1; c0_pc = $urandom; c0_data = $urandom; c0_pdst = 6'd7;
        tick();
        clear_commits();
        wait_valid(4);
        chk("post_reset_seq", out_data[15:8], 0);
        drain(0, 50);

        // Watchdog: constant PC reaches HANG exactly, PC change clears it
        do_reset();
        pc_hold = 1;
        current_pc_i = 32'h1234_5678;
        tick();
        repeat (HANG - 1) tick();
        chk("hang_before", hang_o, 0);
        tick();
        chk("hang_at", hang_o, 1);
        do_reset();
        current_pc_i = 32'h0000_4000;
        tick();
        repeat (HANG - 2) tick();
        current_pc_i = 32'h0000_4004;
        tick();
        repeat (HANG - 1) tick();
        chk("hang_cleared", hang_o, 0);
        pc_hold = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
